// File: rtl/key_event_arbiter_pkg.sv
// key_event_arbiter_pkg
//   Shared definitions for the key event arbiter: key index constants for the
//   vending keypad, default sizing, FSM state type and a small wrap helper.
//   No ports.
package key_event_arbiter_pkg;

  localparam int NUM_KEYS_DEF = 4;
  localparam int CODE_W_DEF   = 2;

  localparam int KEY_COIN5  = 0;
  localparam int KEY_COIN10 = 1;
  localparam int KEY_SELECT = 2;
  localparam int KEY_CANCEL = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  // (idx + 1) mod n without a divider
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// key_event_arbiter_if
//   Valid/ready event stream from the arbiter to the vending controller.
//   evt_valid : event offered
//   evt_code  : key index of the offered event
//   evt_ready : consumer accepts (transfer = evt_valid & evt_ready at clk edge)
//   master = arbiter side, slave = consumer side.
interface key_event_arbiter_if #(
  parameter int CODE_W = 2
) ();
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/key_event_arbiter_rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin picker. Searches req starting at ptr, wrapping
//   modulo NUM_KEYS, and returns the first requesting index.
//   req     : request vector
//   ptr     : search start index
//   gnt_idx : granted index (0 when nothing requests)
//   gnt_any : at least one request present
module rr_priority_picker #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 2
) (
  input  logic [NUM_KEYS-1:0] req,
  input  logic [CODE_W-1:0]   ptr,
  output logic [CODE_W-1:0]   gnt_idx,
  output logic                gnt_any
);

  logic [CODE_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      cand = CODE_W'((int'(ptr) + i) % NUM_KEYS);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
//   Turns rising edges of debounced key levels into pending events and
//   serialises them round-robin onto one valid/ready stream.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   key_lvl : debounced key levels, synchronous to clk
//   key_en  : per-key enable mask (0 = key ignored, pending event dropped)
//   pend    : pending-event flags not yet loaded into the output register
//   overrun : sticky, a key re-pressed while its event was still pending
//   ovr_clr : clears overrun (a same-cycle new overrun wins)
//   evt     : event stream (master side)
//
//   state | meaning
//   IDLE  | output register empty, evt_valid = 0
//   OFFER | event held in output register, evt_valid = 1
module key_event_arbiter
  import key_event_arbiter_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEF,
  parameter int CODE_W   = CODE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_lvl,
  input  logic [NUM_KEYS-1:0] key_en,
  output logic [NUM_KEYS-1:0] pend,
  output logic                overrun,
  input  logic                ovr_clr,
  key_event_arbiter_if.master evt
);

  arb_state_t          state, state_nxt;
  logic [NUM_KEYS-1:0] key_prev;
  logic [NUM_KEYS-1:0] set_mask;
  logic [NUM_KEYS-1:0] req;
  logic [NUM_KEYS-1:0] load_mask;
  logic [NUM_KEYS-1:0] pend_nxt;
  logic [CODE_W-1:0]   ptr;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   gnt_idx;
  logic                gnt_any;
  logic                load;
  logic                ovr_set;

  assign set_mask = key_lvl & ~key_prev & key_en;
  assign ovr_set  = |(set_mask & pend);
  // Disabled keys never get loaded; their pending flag is dropped this edge.
  assign req      = pend & key_en;

  rr_priority_picker #(
    .NUM_KEYS (NUM_KEYS),
    .CODE_W   (CODE_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          load      = 1'b1;
          state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt.evt_ready) begin
          if (gnt_any) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A load clears the old flag; a same-edge rise on that key re-sets it.
  always_comb begin
    load_mask = '0;
    if (load) begin
      load_mask[gnt_idx] = 1'b1;
    end
    pend_nxt = (pend & key_en & ~load_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // key_prev resets high so a key held through reset release is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev <= '1;
      pend     <= '0;
      overrun  <= 1'b0;
      ptr      <= '0;
      code_q   <= '0;
    end else begin
      key_prev <= key_lvl;
      pend     <= pend_nxt;
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (load) begin
        code_q <= gnt_idx;
        ptr    <= CODE_W'(wrap_inc(int'(gnt_idx), NUM_KEYS));
      end
    end
  end

  assign evt.evt_valid = (state == ST_OFFER);
  assign evt.evt_code  = code_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;
  import key_event_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] key_lvl;
  logic [N-1:0] key_en;
  logic [N-1:0] pend;
  logic         overrun;
  logic         ovr_clr;

  key_event_arbiter_if #(.CODE_W(CW)) evt_bus ();

  key_event_arbiter #(.NUM_KEYS(N), .CODE_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_lvl (key_lvl),
    .key_en  (key_en),
    .pend    (pend),
    .overrun (overrun),
    .ovr_clr (ovr_clr),
    .evt     (evt_bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending set, one holding slot, rotating search start.
  bit m_prev [N];
  bit m_pend [N];
  bit m_valid;
  int m_code;
  int m_ptr;
  bit m_ovr;

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b1;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_code  = 0;
    m_ptr   = 0;
    m_ovr   = 1'b0;
  endtask

  // Advance one clock: evaluate the rules on current inputs, then commit #1 after the edge.
  task automatic tick();
    bit s [N];
    bit n_pend [N];
    bit ovr_set, xfer, loaded, clr;
    int k;
    logic [N-1:0] lvl;
    ovr_set = 1'b0;
    loaded  = 1'b0;
    k       = 0;
    lvl     = key_lvl;
    clr     = ovr_clr;
    for (int i = 0; i < N; i++) begin
      s[i] = key_lvl[i] && !m_prev[i] && key_en[i];
      if (s[i] && m_pend[i]) ovr_set = 1'b1;
    end
    xfer = m_valid && evt_bus.evt_ready;
    if (!m_valid || xfer) begin
      for (int off = 0; off < N; off++) begin
        int j;
        j = (m_ptr + off) % N;
        if (!loaded && m_pend[j] && key_en[j]) begin
          loaded = 1'b1;
          k      = j;
        end
      end
    end
    for (int i = 0; i < N; i++)
      n_pend[i] = (m_pend[i] && key_en[i] && !(loaded && i == k)) || s[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = n_pend[i];
      m_prev[i] = lvl[i];
    end
    if (loaded) begin
      m_valid = 1'b1;
      m_code  = k;
      m_ptr   = (k + 1) % N;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (ovr_set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    key_lvl = 4'b0010;
    key_en  = 4'b1111;
    ovr_clr = 1'b0;
    evt_bus.evt_ready = 1'b1;
    #2 reset = 1'b1;
    #3;
    checks++;
    if ({evt_bus.evt_valid, evt_bus.evt_code, pend, overrun} !== 8'b0) begin
      failures++;
      $display("FAIL reset_vals valid=%b code=%0d pend=%b ovr=%b exp all 0",
               evt_bus.evt_valid, evt_bus.evt_code, pend, overrun);
    end
    @(posedge clk);
    #5 reset = 1'b0;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (evt_bus.evt_valid !== 1'b0 || pend !== 4'b0) begin
        failures++;
        $display("FAIL held_key_no_evt cyc=%0d valid=%b pend=%b exp 0/0000", c, evt_bus.evt_valid, pend);
      end
    end
    key_lvl = 4'b0000;
    tick();
    key_lvl = 4'b0010;
    tick();
    checks++;
    if (pend !== 4'b0010 || evt_bus.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_e0 pend=%b valid=%b exp 0010/0", pend, evt_bus.evt_valid);
    end
    tick();
    checks++;
    if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_code !== 2'd1) begin
      failures++;
      $display("FAIL lat_e1 valid=%b code=%0d exp 1/1", evt_bus.evt_valid, evt_bus.evt_code);
    end
    tick();
    checks++;
    if (evt_bus.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL consume1 valid=%b exp 0", evt_bus.evt_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] exp_codes [4];
    exp_codes[0] = 2'd0; exp_codes[1] = 2'd2; exp_codes[2] = 2'd3; exp_codes[3] = 2'd0;
    key_lvl = 4'b0000;
    key_en  = 4'b1111;
    evt_bus.evt_ready = 1'b1;
    do_reset();
    tick();
    for (int p = 0; p < 2; p++) begin
      key_lvl = (p == 0) ? 4'b0101 : 4'b1001;
      tick();
      checks++;
      if (pend !== key_lvl) begin
        failures++;
        $display("FAIL rr_pend pair=%0d pend=%b exp %b", p, pend, key_lvl);
      end
      for (int e = 0; e < 2; e++) begin
        tick();
        checks++;
        if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_code !== exp_codes[2*p+e]) begin
          failures++;
          $display("FAIL rr_code pair=%0d ev=%0d valid=%b code=%0d exp 1/%0d",
                   p, e, evt_bus.evt_valid, evt_bus.evt_code, exp_codes[2*p+e]);
        end
      end
      tick();
      checks++;
      if (evt_bus.evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle pair=%0d valid=%b exp 0", p, evt_bus.evt_valid);
      end
      key_lvl = 4'b0000;
      tick();
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] pat [6];
    pat[0] = 4'b0110; pat[1] = 4'b0010; pat[2] = 4'b0110;
    pat[3] = 4'b0110; pat[4] = 4'b0110; pat[5] = 4'b0110;
    key_lvl = 4'b0000;
    key_en  = 4'b1111;
    evt_bus.evt_ready = 1'b0;
    do_reset();
    tick();
    key_lvl = 4'b0010;
    tick();
    tick();
    for (int c = 0; c < 6; c++) begin
      key_lvl = pat[c];
      tick();
      checks++;
      if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_code !== 2'd1) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b code=%0d exp 1/1", c, evt_bus.evt_valid, evt_bus.evt_code);
      end
    end
    checks++;
    if (pend !== 4'b0100 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL stall_ovr pend=%b ovr=%b exp 0100/1", pend, overrun);
    end
    evt_bus.evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_code !== 2'd2 || overrun !== 1'b1 || pend !== 4'b0) begin
      failures++;
      $display("FAIL stall_next valid=%b code=%0d ovr=%b pend=%b exp 1/2/1/0000",
               evt_bus.evt_valid, evt_bus.evt_code, overrun, pend);
    end
  endtask

  task automatic test_enable();
    key_lvl = 4'b0000;
    key_en  = 4'b1011;
    evt_bus.evt_ready = 1'b0;
    do_reset();
    tick();
    key_lvl = 4'b0100;
    tick();
    tick();
    checks++;
    if (pend !== 4'b0 || evt_bus.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL en_masked pend=%b valid=%b exp 0000/0", pend, evt_bus.evt_valid);
    end
    key_lvl = 4'b0101;
    tick();
    tick();
    key_lvl = 4'b1101;
    tick();
    checks++;
    if (pend !== 4'b1000 || evt_bus.evt_code !== 2'd0) begin
      failures++;
      $display("FAIL en_pend3 pend=%b code=%0d exp 1000/0", pend, evt_bus.evt_code);
    end
    key_en = 4'b0011;
    tick();
    checks++;
    if (pend !== 4'b0) begin
      failures++;
      $display("FAIL en_drop pend=%b exp 0000", pend);
    end
    evt_bus.evt_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (evt_bus.evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL en_never cyc=%0d valid=%b code=%0d exp valid 0", c, evt_bus.evt_valid, evt_bus.evt_code);
      end
    end
    key_en = 4'b1111;
  endtask

  task automatic test_async_reset();
    key_lvl = 4'b0000;
    key_en  = 4'b1111;
    evt_bus.evt_ready = 1'b0;
    do_reset();
    tick();
    key_lvl = 4'b0010; tick(); tick();
    key_lvl = 4'b0110; tick();
    key_lvl = 4'b0010; tick();
    key_lvl = 4'b0110; tick();
    #4 reset = 1'b1;
    #2;
    checks++;
    if (evt_bus.evt_valid !== 1'b0 || pend !== 4'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL async_rst valid=%b pend=%b ovr=%b exp 0/0000/0", evt_bus.evt_valid, pend, overrun);
    end
    @(posedge clk);
    #5 reset = 1'b0;
    model_reset();
    evt_bus.evt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (evt_bus.evt_valid !== 1'b0 || pend !== 4'b0) begin
        failures++;
        $display("FAIL no_reissue cyc=%0d valid=%b pend=%b exp 0/0000", c, evt_bus.evt_valid, pend);
      end
    end
  endtask

  task automatic test_ovr_clr();
    key_lvl = 4'b0000;
    key_en  = 4'b1111;
    ovr_clr = 1'b0;
    evt_bus.evt_ready = 1'b0;
    do_reset();
    tick();
    key_lvl = 4'b0001; tick(); tick();
    key_lvl = 4'b0011; tick();
    key_lvl = 4'b0001; tick();
    key_lvl = 4'b0011; tick();
    key_lvl = 4'b0001; tick();
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_setup ovr=%b exp 1", overrun);
    end
    key_lvl = 4'b0011;
    ovr_clr = 1'b1;
    tick();
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins ovr=%b exp 1", overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear ovr=%b exp 0", overrun);
    end
    ovr_clr = 1'b0;
  endtask

  task automatic test_random();
    key_lvl = 4'b0000;
    key_en  = 4'b1111;
    ovr_clr = 1'b0;
    evt_bus.evt_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) key_lvl[i] = ~key_lvl[i];
        key_en[i] = ($urandom_range(0, 9) != 0);
      end
      evt_bus.evt_ready = ($urandom_range(0, 9) < 6);
      ovr_clr = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (evt_bus.evt_valid !== m_valid || (m_valid && evt_bus.evt_code !== CW'(m_code)) ||
          pend !== m_pend_vec() || overrun !== m_ovr) begin
        failures++;
        $display("FAIL rand cyc=%0d valid=%b code=%0d pend=%b ovr=%b exp %b/%0d/%b/%b",
                 c, evt_bus.evt_valid, evt_bus.evt_code, pend, overrun,
                 m_valid, m_code, m_pend_vec(), m_ovr);
      end
    end
    ovr_clr = 1'b0;
    key_en  = 4'b1111;
  endtask

  initial begin
    reset   = 1'b0;
    key_lvl = '0;
    key_en  = '1;
    ovr_clr = 1'b0;
    evt_bus.evt_ready = 1'b1;
    model_reset();
    test_reset();
    test_round_robin();
    test_stall();
    test_enable();
    test_async_reset();
    test_ovr_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
